dsp_decim_top: RTL

- Parametrised successor to the fixed pass-through/FIR DSP stage: sits between the AD capture path (ad_data/ad_vld) and the sample memory writer (sm_data/sm_vld).
- Adds a run-time selectable accumulate-and-dump decimator (2^k samples summed), programmable arithmetic right shift, signed saturation and bypass.
- Configured and monitored over the fx register bus, decoded against dev_id.

---
 rtl/dsp_decim_pkg.sv | 20 ++
 rtl/dsp_decim_regs.sv | 106 ++++++++++
 rtl/dsp_decim_top.sv | 119 +++++++++++
 3 files changed

// File: rtl/dsp_decim_pkg.sv
// Shared register map, reset values and control bit positions for the
// decimating DSP stage between AD capture and the sample memory writer.
package dsp_decim_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_DEC    = 8'h01;
    localparam logic [7:0] OFF_SHIFT  = 8'h02;
    localparam logic [7:0] OFF_STAT   = 8'h03;
    localparam logic [7:0] OFF_OCNT_L = 8'h04;
    localparam logic [7:0] OFF_OCNT_H = 8'h05;
    localparam logic [7:0] OFF_ID     = 8'h06;

    localparam logic [7:0] CTRL_RST  = 8'h01;
    localparam logic [7:0] DEC_RST   = 8'h00;
    localparam logic [7:0] SHIFT_RST = 8'h00;

    localparam int BYPASS_BIT  = 0;
    localparam int SAT_CLR_BIT = 1;

endpackage

// File: rtl/dsp_decim_regs.sv
// fx register bus decode, configuration registers, sticky saturation flag
// and output-sample counter for dsp_decim_top.
module dsp_decim_regs
    import dsp_decim_pkg::*;
#(
    parameter int          MAX_LOG2_DEC = 6,
    parameter int          ACC_W        = 22,
    parameter logic [7:0]  VERSION      = 8'h02
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        fx_wr,
    input  logic [21:0] fx_waddr,
    input  logic [7:0]  fx_data,
    input  logic        fx_rd,
    input  logic [21:0] fx_raddr,
    input  logic [5:0]  dev_id,
    input  logic        sat_set,
    input  logic        out_vld,
    output logic        cfg_bypass,
    output logic [3:0]  cfg_k,
    output logic [4:0]  cfg_shift,
    output logic        flush,
    output logic [7:0]  fx_q
);

    logic        wr_hit_s;
    logic        rd_hit_s;
    logic        sat_clr_s;
    logic [3:0]  dec_wval_s;
    logic [4:0]  shift_wval_s;
    logic [7:0]  rd_val_s;
    logic        bypass_r;
    logic [3:0]  k_r;
    logic [4:0]  shift_r;
    logic        sat_r;
    logic [15:0] ocnt_r;
    logic        unused_bits_s;

    assign unused_bits_s = ^{fx_waddr[15:8], fx_raddr[15:8], fx_data[7:5]};

    assign cfg_bypass = bypass_r;
    assign cfg_k      = k_r;
    assign cfg_shift  = shift_r;

    // Address decode, write-side clamping and read mux
    always_comb begin
        wr_hit_s  = fx_wr && (fx_waddr[21:16] == dev_id);
        rd_hit_s  = fx_rd && (fx_raddr[21:16] == dev_id);
        flush     = wr_hit_s && ((fx_waddr[7:0] == OFF_CTRL) || (fx_waddr[7:0] == OFF_DEC));
        sat_clr_s = wr_hit_s && (fx_waddr[7:0] == OFF_CTRL) && fx_data[SAT_CLR_BIT];
        if (fx_data[3:0] > 4'(MAX_LOG2_DEC)) begin
            dec_wval_s = 4'(MAX_LOG2_DEC);
        end else begin
            dec_wval_s = fx_data[3:0];
        end
        if (fx_data[4:0] > 5'(ACC_W - 1)) begin
            shift_wval_s = 5'(ACC_W - 1);
        end else begin
            shift_wval_s = fx_data[4:0];
        end
        case (fx_raddr[7:0])
            OFF_CTRL:   rd_val_s = {7'b0000000, bypass_r};
            OFF_DEC:    rd_val_s = {4'b0000, k_r};
            OFF_SHIFT:  rd_val_s = {3'b000, shift_r};
            OFF_STAT:   rd_val_s = {7'b0000000, sat_r};
            OFF_OCNT_L: rd_val_s = ocnt_r[7:0];
            OFF_OCNT_H: rd_val_s = ocnt_r[15:8];
            OFF_ID:     rd_val_s = VERSION;
            default:    rd_val_s = 8'h00;
        endcase
    end

    // Register file, sticky SAT (set beats clear), output counter, read data
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            bypass_r <= CTRL_RST[BYPASS_BIT];
            k_r      <= DEC_RST[3:0];
            shift_r  <= SHIFT_RST[4:0];
            sat_r    <= 1'b0;
            ocnt_r   <= 16'h0000;
            fx_q     <= 8'h00;
        end else begin
            if (wr_hit_s) begin
                case (fx_waddr[7:0])
                    OFF_CTRL:  bypass_r <= fx_data[BYPASS_BIT];
                    OFF_DEC:   k_r      <= dec_wval_s;
                    OFF_SHIFT: shift_r  <= shift_wval_s;
                    default:   bypass_r <= bypass_r;
                endcase
            end
            if (sat_set) begin
                sat_r <= 1'b1;
            end else if (sat_clr_s) begin
                sat_r <= 1'b0;
            end
            if (out_vld) begin
                ocnt_r <= ocnt_r + 16'h0001;
            end
            if (fx_rd) begin
                fx_q <= rd_hit_s ? rd_val_s : 8'h00;
            end
        end
    end

endmodule

// File: rtl/dsp_decim_top.sv
// AD-to-sample-memory DSP stage: bypass or accumulate-and-dump decimation by
// 2^k with arithmetic right shift and signed saturation.
module dsp_decim_top
    import dsp_decim_pkg::*;
#(
    parameter int         DW           = 16,
    parameter int         MAX_LOG2_DEC = 6,
    parameter logic [7:0] VERSION      = 8'h02
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic [DW-1:0] ad_data,
    input  logic          ad_vld,
    output logic [DW-1:0] sm_data,
    output logic          sm_vld,
    input  logic          fx_wr,
    input  logic [21:0]   fx_waddr,
    input  logic [7:0]    fx_data,
    input  logic          fx_rd,
    input  logic [21:0]   fx_raddr,
    output logic [7:0]    fx_q,
    input  logic [5:0]    dev_id
);

    localparam int ACC_W = DW + MAX_LOG2_DEC;
    localparam int CNT_W = MAX_LOG2_DEC + 1;
    localparam int HI_W  = ACC_W - DW + 1;

    logic                    cfg_bypass_s;
    logic [3:0]              cfg_k_s;
    logic [4:0]              cfg_shift_s;
    logic                    flush_s;
    logic                    sat_set_s;
    logic signed [ACC_W-1:0] ad_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] shifted_s;
    logic [HI_W-1:0]         hi_s;
    logic [CNT_W-1:0]        dec_len_s;
    logic                    last_s;
    logic                    ovf_s;
    logic [DW-1:0]           sat_val_s;
    logic signed [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0]        cnt_r;

    dsp_decim_regs #(
        .MAX_LOG2_DEC (MAX_LOG2_DEC),
        .ACC_W        (ACC_W),
        .VERSION      (VERSION)
    ) u_regs (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .fx_wr      (fx_wr),
        .fx_waddr   (fx_waddr),
        .fx_data    (fx_data),
        .fx_rd      (fx_rd),
        .fx_raddr   (fx_raddr),
        .dev_id     (dev_id),
        .sat_set    (sat_set_s),
        .out_vld    (sm_vld),
        .cfg_bypass (cfg_bypass_s),
        .cfg_k      (cfg_k_s),
        .cfg_shift  (cfg_shift_s),
        .flush      (flush_s),
        .fx_q       (fx_q)
    );

    // Dump value: sum including current sample, floor shift, clamp to DW signed
    always_comb begin
        ad_ext_s  = {{MAX_LOG2_DEC{ad_data[DW-1]}}, ad_data};
        sum_s     = acc_r + ad_ext_s;
        shifted_s = sum_s >>> cfg_shift_s;
        dec_len_s = CNT_W'(1) << cfg_k_s;
        last_s    = (cnt_r == (dec_len_s - CNT_W'(1)));
        hi_s      = shifted_s[ACC_W-1:DW-1];
        if ((hi_s == {HI_W{1'b0}}) || (hi_s == {HI_W{1'b1}})) begin
            ovf_s     = 1'b0;
            sat_val_s = shifted_s[DW-1:0];
        end else if (shifted_s[ACC_W-1]) begin
            ovf_s     = 1'b1;
            sat_val_s = {1'b1, {(DW-1){1'b0}}};
        end else begin
            ovf_s     = 1'b1;
            sat_val_s = {1'b0, {(DW-1){1'b1}}};
        end
        sat_set_s = !cfg_bypass_s && !flush_s && ad_vld && last_s && ovf_s;
    end

    // Accumulator, sample counter and registered output; a config flush
    // discards any sample arriving with it
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sm_data <= {DW{1'b0}};
            sm_vld  <= 1'b0;
        end else if (cfg_bypass_s) begin
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sm_data <= ad_data;
            sm_vld  <= ad_vld;
        end else if (flush_s) begin
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sm_vld  <= 1'b0;
        end else if (ad_vld && last_s) begin
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sm_data <= sat_val_s;
            sm_vld  <= 1'b1;
        end else if (ad_vld) begin
            acc_r   <= sum_s;
            cnt_r   <= cnt_r + CNT_W'(1);
            sm_vld  <= 1'b0;
        end else begin
            sm_vld  <= 1'b0;
        end
    end

endmodule
